sq_err_sweep_ctrl: RTL and testbench
====================================

// Module: sq_err_sweep_ctrl
// PURPOSE
//  Sequencer for exhaustive error evaluation of a combinational approximate squarer.
//  - Drives every input vector 0..2^IN_W-1 into the approximate circuit and the exact model.
//  - Captures both results and accumulates error statistics.
//  - Presents the final metrics to the evaluation host.
//  - Sits between the host start/abort interface and the circuit-under-evaluation pair.
// PARAMETERS
//  IN_W   12  width of input vector driven to both circuits
//  OUT_W  14  width of approximate and exact result buses
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  start      in   1              begin sweep; sampled in IDLE or DONE only
//  abort      in   1              cancel sweep; any state -> IDLE
//  vec        out  IN_W           stimulus to approx and exact circuits (registered)
//  approx_res in   OUT_W          approximate circuit output for vec (combinational path)
//  exact_res  in   OUT_W          exact circuit output for vec (combinational path)
//  busy       out  1              high in SWEEP and DRAIN
//  done       out  1              high in DONE; metrics valid and stable
//  err_cnt    out  IN_W+1         number of vectors with approx_res != exact_res
//  max_err    out  OUT_W          largest |approx_res - exact_res|
//  worst_vec  out  IN_W           first vec that produced max_err
//  sum_err    out  IN_W+OUT_W     sum of |approx_res - exact_res| over all vectors
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE.
//    - vec, err_cnt, max_err, worst_vec, sum_err = 0.
//    - busy = 0, done = 0, capture-valid = 0.
//  - N = 2^IN_W. States: IDLE, SWEEP, DRAIN, DONE. All outputs are registered.
//  - IDLE, start=1: -> SWEEP.
//    - vec <= 0; all metrics cleared; capture-valid cleared.
//  - SWEEP, each edge:
//    - Capture stage <= {approx_res, exact_res, vec}; capture-valid <= 1.
//    - If vec == N-1: -> DRAIN and vec holds at N-1 (no wrap). Otherwise vec <= vec+1.
//  - Accumulate stage, on every edge with capture-valid=1:
//    - d = |cap_approx - cap_exact|, unsigned, OUT_W bits.
//    - If d != 0: err_cnt += 1.
//    - sum_err += d. Width is sufficient, so no saturation or overflow check exists.
//    - If d > max_err (strictly greater): max_err <= d and worst_vec <= cap_vec.
//      On ties the earliest vector is kept.
//  - DRAIN: accumulates the last capture.
//    - capture-valid <= 0; -> DONE. done=1 from this edge on.
//  - Latency: start sampled at edge E0 -> done first high after edge E(N+1).
//    - That is N+1 cycles after the start edge: 4097 for IN_W=12.
//    - busy is high for exactly N+1 cycles.
//  - DONE: metrics held.
//    - start=1 restarts: -> SWEEP with metrics cleared, done <= 0 on the same edge.
//  - start while busy: ignored.
//  - abort=1, any state: -> IDLE on the next edge.
//    - busy=0, done=0, capture-valid=0, vec <= 0.
//    - Metrics keep their partial values; done=0 marks them invalid.
//  - abort and start in the same cycle: abort wins.
//  - Reset mid-sweep: immediate return to the reset state; no partial result retained.
// TESTING
//  1 approx_res==exact_res for all vec, pulse start
//    -> done after 4097 cycles; err_cnt=0, max_err=0, sum_err=0, worst_vec=0.
//  2 approx_res = exact_res+1 for all vec
//    -> err_cnt=4096, sum_err=4096, max_err=1, worst_vec=0 (tie keeps first).
//  3 single error of 5 at vec=0xABC, and error of 5 again at 0xFFF
//    -> err_cnt=2, sum_err=10, max_err=5, worst_vec=0xABC.
//  4 abort when vec=100
//    -> next cycle busy=0, done=0, vec=0; a new start then gives full-sweep results as in test 1.
//  5 start pulsed during SWEEP at vec=50
//    -> ignored; done still at cycle 4097 after the original start.
//    Also: start in DONE restarts and clears the metrics.
//  6 rst_n low mid-sweep, asynchronous to clk
//    -> all outputs 0 immediately; start after release gives a correct full sweep.

Source files
------------

// File: rtl/sq_err_sweep_ctrl.sv
// Exhaustive error sweep sequencer for an approximate squarer: walks every input
// vector, compares the approximate and exact results one cycle later, and accumulates error metrics.
module sq_err_sweep_ctrl #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [IN_W-1:0]       vec,
    input  logic [OUT_W-1:0]      approx_res,
    input  logic [OUT_W-1:0]      exact_res,
    output logic                  busy,
    output logic                  done,
    output logic [IN_W:0]         err_cnt,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W-1:0]       worst_vec,
    output logic [IN_W+OUT_W-1:0] sum_err,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IN_W-1:0] VEC_LAST = '1;
    localparam logic [IN_W-1:0] VEC_ONE  = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [IN_W:0]   ERR_ONE  = {{IN_W{1'b0}}, 1'b1};

    state_t state, state_next;
    logic   launch;

    logic                 cap_valid;
    logic [OUT_W-1:0]     cap_approx;
    logic [OUT_W-1:0]     cap_exact;
    logic [IN_W-1:0]      cap_vec;
    logic [OUT_W-1:0]     diff;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Handshake: start is only honoured in IDLE/DONE; abort overrides everything, start included.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_SWEEP;
                    launch     = 1'b1;
                end
            end
            S_SWEEP: if (vec == VEC_LAST) state_next = S_DRAIN;
            S_DRAIN: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
            launch     = 1'b0;
        end
    end

    assign diff = (cap_approx >= cap_exact) ? (cap_approx - cap_exact)
                                            : (cap_exact - cap_approx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cap_valid  <= 1'b0;
            cap_approx <= '0;
            cap_exact  <= '0;
            cap_vec    <= '0;
            err_cnt    <= '0;
            max_err    <= '0;
            worst_vec  <= '0;
            sum_err    <= '0;
        end else begin
            busy <= (state_next == S_SWEEP) || (state_next == S_DRAIN);
            done <= (state_next == S_DONE);

            if (state == S_SWEEP && !abort) begin
                cap_approx <= approx_res;
                cap_exact  <= exact_res;
                cap_vec    <= vec;
                cap_valid  <= 1'b1;
            end else begin
                cap_valid  <= 1'b0;
            end

            // vec parks on the last vector rather than wrapping while the pipe drains
            if (abort || launch)
                vec <= '0;
            else if (state == S_SWEEP && vec != VEC_LAST)
                vec <= vec + VEC_ONE;

            if (launch) begin
                err_cnt   <= '0;
                max_err   <= '0;
                worst_vec <= '0;
                sum_err   <= '0;
            end else if (cap_valid) begin
                if (diff != '0)
                    err_cnt <= err_cnt + ERR_ONE;
                sum_err <= sum_err + {{IN_W{1'b0}}, diff};
                if (diff > max_err) begin
                    max_err   <= diff;
                    worst_vec <= cap_vec;
                end
            end
        end
    end

endmodule

// File: tb/tb_sq_err_sweep_ctrl.sv
// Bench for sq_err_sweep_ctrl: a behavioural approximate/exact squarer pair with
// selectable error patterns, sweep launches queued against a done-edge monitor.
module tb_sq_err_sweep_ctrl;

    localparam int IN_W  = 12;
    localparam int OUT_W = 14;
    localparam int N     = 1 << IN_W;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [IN_W-1:0]       vec;
    logic [OUT_W-1:0]      approx_res;
    logic [OUT_W-1:0]      exact_res;
    logic                  busy;
    logic                  done;
    logic [IN_W:0]         err_cnt;
    logic [OUT_W-1:0]      max_err;
    logic [IN_W-1:0]       worst_vec;
    logic [IN_W+OUT_W-1:0] sum_err;
    logic [1:0]            state_dbg;

    int         cyc      = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] mode     = 2'd0;
    logic       done_prev = 1'b0;

    typedef struct packed {
        logic [IN_W:0]         err;
        logic [OUT_W-1:0]      mx;
        logic [IN_W-1:0]       worst;
        logic [IN_W+OUT_W-1:0] sum;
        logic [31:0]           done_cyc;
    } exp_t;

    exp_t exp_q[$];

    sq_err_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .vec        (vec),
        .approx_res (approx_res),
        .exact_res  (exact_res),
        .busy       (busy),
        .done       (done),
        .err_cnt    (err_cnt),
        .max_err    (max_err),
        .worst_vec  (worst_vec),
        .sum_err    (sum_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, required < 100000", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- circuit-under-evaluation models ----------------
    logic [31:0] sq;
    always_comb begin
        sq        = {20'd0, vec} * {20'd0, vec};
        exact_res = sq[23:10];
        approx_res = exact_res;
        case (mode)
            2'd1: approx_res = exact_res + 14'd1;
            2'd2: if (vec == 12'hABC || vec == 12'hFFF) approx_res = exact_res + 14'd5;
            2'd3: begin
                if (vec == 12'h123)      approx_res = exact_res + 14'd7;
                else if (vec == 12'h800) approx_res = exact_res - 14'd3;
                else if (vec == 12'h900) approx_res = exact_res - 14'd7;
            end
            default: approx_res = exact_res;
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done rise at cycle %0d, required no pending sweep", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("err_cnt",   64'(err_cnt),   64'(e.err));
                check("max_err",   64'(max_err),   64'(e.mx));
                check("worst_vec", 64'(worst_vec), 64'(e.worst));
                check("sum_err",   64'(sum_err),   64'(e.sum));
                check("latency",   64'(cyc),       64'(e.done_cyc));
            end
        end
        done_prev = done;
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [1:0] m, input exp_t e);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        e.done_cyc = 32'(cyc + N + 2);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < N + 100; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL wait_done: got no done within %0d cycles, required done", N + 100);
        end
    endtask

    task automatic wait_vec(input logic [IN_W-1:0] target);
        bit got = 0;
        for (int i = 0; i < N + 100; i++) begin
            @(negedge clk);
            if (vec == target) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL wait_vec: got vec never reaching 0x%0h, required reach", target);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},       64'(vec),       64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_err_cnt"},   64'(err_cnt),   64'd0);
        check({tag, "_max_err"},   64'(max_err),   64'd0);
        check({tag, "_worst_vec"}, 64'(worst_vec), 64'd0);
        check({tag, "_sum_err"},   64'(sum_err),   64'd0);
    endtask

    // ---------------- directed stimulus ----------------
    localparam exp_t EXP_CLEAN  = '{err: 13'd0,    mx: 14'd0, worst: 12'h000, sum: 26'd0,    done_cyc: 32'd0};
    localparam exp_t EXP_ALL1   = '{err: 13'd4096, mx: 14'd1, worst: 12'h000, sum: 26'd4096, done_cyc: 32'd0};
    localparam exp_t EXP_TWO5   = '{err: 13'd2,    mx: 14'd5, worst: 12'hABC, sum: 26'd10,   done_cyc: 32'd0};
    localparam exp_t EXP_MIXED  = '{err: 13'd3,    mx: 14'd7, worst: 12'h123, sum: 26'd17,   done_cyc: 32'd0};

    initial begin
        // reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // all-exact sweep
        launch(2'd0, EXP_CLEAN);
        check("sweep_busy", 64'(busy), 64'd1);
        wait_done();

        // restart from DONE into the off-by-one pattern
        launch(2'd1, EXP_ALL1);
        wait_done();
        repeat (3) @(negedge clk);
        check("held_err_cnt", 64'(err_cnt), 64'd4096);
        check("held_done",    64'(done),    64'd1);

        // restart from DONE must clear the metrics on the start edge
        launch(2'd2, EXP_TWO5);
        check("restart_done",    64'(done),    64'd0);
        check("restart_busy",    64'(busy),    64'd1);
        check("restart_err_cnt", 64'(err_cnt), 64'd0);
        check("restart_sum_err", 64'(sum_err), 64'd0);
        wait_done();

        // mixed signs and a tie, with a start pulse mid-sweep that must be ignored
        launch(2'd3, EXP_MIXED);
        wait_vec(12'd50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_busy", 64'(busy), 64'd1);
        wait_done();

        // abort at vec=100
        launch(2'd0, EXP_CLEAN);
        wait_vec(12'd100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(exp_q.pop_back());
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_vec",  64'(vec),  64'd0);

        // abort and start together: stays idle
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_wins_busy", 64'(busy), 64'd0);
        check("abort_wins_vec",  64'(vec),  64'd0);

        launch(2'd0, EXP_CLEAN);
        wait_done();

        // asynchronous reset mid-sweep
        launch(2'd1, EXP_ALL1);
        wait_vec(12'd300);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        launch(2'd3, EXP_MIXED);
        wait_done();

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
